// File: rtl/fifo_fwft_rd_pkg.sv
// Shared definitions for the FWFT read controller: mem read-mode strings,
// read-latency legality check and a constant clog2 helper.
package fifo_fwft_rd_pkg;

    localparam string SHOW_AHEAD_OFF = "OFF";
    localparam string SHOW_AHEAD_ON  = "ON";

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Circular register FIFO with a combinational head output. Pointers wrap
// modulo BUF_DEPTH, so non-power-of-2 depths work.
module fifo_skid_buf
    import fifo_fwft_rd_pkg::*;
#(
    parameter int  DATA_SIZE = 8,
    parameter int  BUF_DEPTH = 2,
    localparam int PTR_W     = clog2(BUF_DEPTH),
    localparam int LVL_W     = clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic                 rd_i,
    output logic [DATA_SIZE-1:0] head_o,
    output logic [LVL_W-1:0]     level_o,
    output logic                 empty_o
);

    logic [DATA_SIZE-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        head_d  = rd_i ? ptr_inc(head_q) : head_q;
        tail_d  = wr_i ? ptr_inc(tail_q) : tail_q;
        level_d = level_q + LVL_W'(wr_i) - LVL_W'(rd_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            if (wr_i) mem_q[tail_q] <= wr_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);
    assign full    = (level_q == LVL_W'(BUF_DEPTH));

    // The credit rule upstream must make both of these unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_i && full && !rd_i));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_i && empty_o));

endmodule

// File: rtl/fifo_fwft_rd.sv
// Read-side controller: issues mem reads against skid-buffer credit, tracks
// in-flight reads, and presents the result as a FWFT valid/ready stream.
module fifo_fwft_rd
    import fifo_fwft_rd_pkg::*;
#(
    parameter int  DATA_SIZE  = 8,
    parameter int  RD_LATENCY = 1,
    localparam int BUF_DEPTH  = RD_LATENCY + 1,
    localparam int LVL_W      = clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk_rd,
    input  logic                 rst,
    input  logic                 mem_empty,
    output logic                 mem_rd_en,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [LVL_W-1:0]     level
);

    localparam int CR_W = LVL_W + 1;

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("fifo_fwft_rd: RD_LATENCY must be 1 or 2");
    end

    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CR_W-1:0]       inflt;
    logic [CR_W-1:0]       credit;
    logic                  ret, pop, buf_empty, buf_wr, buf_rd;
    logic [DATA_SIZE-1:0]  head;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = mem_rd_en;
        for (int k = 1; k < RD_LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    end

    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    // Every issued read, including the one returning this cycle, holds a slot.
    always_comb begin
        inflt = '0;
        for (int k = 0; k < RD_LATENCY; k++) inflt = inflt + CR_W'(vld_pipe_q[k]);
    end

    assign ret = vld_pipe_q[RD_LATENCY-1];

    // A word returning into an empty buffer is shown straight from mem, so
    // dout_valid tracks the return cycle and a same-cycle pop skips the buffer.
    assign dout_valid = !buf_empty || ret;
    assign dout       = (buf_empty && ret) ? mem_rd_data : head;
    assign pop        = dout_valid && dout_ready;
    assign buf_rd     = pop && !buf_empty;
    assign buf_wr     = ret && !(pop && buf_empty);

    assign credit    = CR_W'(level) + inflt - CR_W'(pop);
    assign mem_rd_en = !rst && !mem_empty && (credit < CR_W'(BUF_DEPTH));

    fifo_skid_buf #(
        .DATA_SIZE (DATA_SIZE),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk       (clk_rd),
        .rst       (rst),
        .wr_i      (buf_wr),
        .wr_data_i (mem_rd_data),
        .rd_i      (buf_rd),
        .head_o    (head),
        .level_o   (level),
        .empty_o   (buf_empty)
    );

endmodule

// File: tb/tb_fifo_fwft_rd.sv
// Bench for fifo_fwft_rd: lane 0 runs RD_LATENCY=1, lane 1 RD_LATENCY=2, both
// fed from one source array through their own registered-read mem models.
module tb_fifo_fwft_rd;

    localparam int DW = 8;
    localparam int NL = 2;

    logic clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    logic          rst;
    logic          dout_ready;
    logic [DW-1:0] src [64];
    int            src_cnt;
    int            n_pass, n_total;
    int            exp_idx [NL];
    int            pops [NL], first [NL], last [NL];

    logic          mem_empty   [NL];
    logic          mem_rd_en   [NL];
    logic [DW-1:0] mem_rd_data [NL];
    logic [DW-1:0] dout        [NL];
    logic          dout_valid  [NL];
    logic [1:0]    level       [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LAT = g + 1;
        int            rd_ptr;
        logic [DW-1:0] pipe [LAT];

        assign mem_empty[g]   = (rd_ptr >= src_cnt);
        assign mem_rd_data[g] = pipe[LAT-1];

        always @(posedge clk_rd or posedge rst) begin
            if (rst)               rd_ptr <= 0;
            else if (mem_rd_en[g]) rd_ptr <= rd_ptr + 1;
        end

        always @(posedge clk_rd) begin
            if (mem_rd_en[g]) pipe[0] <= src[rd_ptr];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        fifo_fwft_rd #(
            .DATA_SIZE  (DW),
            .RD_LATENCY (LAT)
        ) u_dut (
            .clk_rd      (clk_rd),
            .rst         (rst),
            .mem_empty   (mem_empty[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_rd_data (mem_rd_data[g]),
            .dout        (dout[g]),
            .dout_valid  (dout_valid[g]),
            .dout_ready  (dout_ready),
            .level       (level[g])
        );
    end

    typedef struct {
        bit         load;
        bit         ready;
        bit         en0;
        bit         vld0;
        bit         chk_dout;
        logic [7:0] dout0;
        logic [1:0] lvl0;
        bit         en1;
        bit         vld1;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h", name, lane, act, exp);
    endtask

    task automatic sb_check();
        for (int g = 0; g < NL; g++) begin
            if (!rst && dout_valid[g] && dout_ready) begin
                chk("sb_order", g, 32'(dout[g]), 32'(src[exp_idx[g]]));
                exp_idx[g]++;
            end
        end
    endtask

    task automatic step();
        sb_check();
        @(posedge clk_rd);
        @(negedge clk_rd);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            step();
        end
    endtask

    task automatic chk_idle(input string name);
        for (int g = 0; g < NL; g++) begin
            chk({name, "_rd_en"}, g, 32'(mem_rd_en[g]), 32'd0);
            chk({name, "_valid"}, g, 32'(dout_valid[g]), 32'd0);
            chk({name, "_level"}, g, 32'(level[g]), 32'd0);
            chk({name, "_dout"}, g, 32'(dout[g]), 32'd0);
        end
    endtask

    task automatic count_pops(input int ncyc);
        for (int g = 0; g < NL; g++) begin
            pops[g] = 0; first[g] = -1; last[g] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            #1;
            for (int g = 0; g < NL; g++) begin
                if (dout_valid[g] && dout_ready) begin
                    if (pops[g] == 0) first[g] = c;
                    last[g] = c;
                    pops[g]++;
                end
            end
            step();
        end
    endtask

    initial begin
        //         load  rdy   en0   vld0  chkd  dout0  lvl0  en1   vld1
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd0, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};

        n_pass = 0; n_total = 0; src_cnt = 0;
        for (int i = 0; i < 64; i++) src[i] = '0;
        for (int g = 0; g < NL; g++) exp_idx[g] = 0;
        rst = 1'b1; dout_ready = 1'b0;
        @(negedge clk_rd);
        @(negedge clk_rd);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        step();

        // latency: mem_empty falls with an empty buffer
        src[0] = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            if (tv[i].load) src_cnt++;
            dout_ready = tv[i].ready;
            #1;
            chk("lat_rd_en", 0, 32'(mem_rd_en[0]), 32'(tv[i].en0));
            chk("lat_valid", 0, 32'(dout_valid[0]), 32'(tv[i].vld0));
            chk("lat_level", 0, 32'(level[0]), 32'(tv[i].lvl0));
            if (tv[i].chk_dout) chk("lat_dout", 0, 32'(dout[0]), 32'(tv[i].dout0));
            chk("lat_rd_en", 1, 32'(mem_rd_en[1]), 32'(tv[i].en1));
            chk("lat_valid", 1, 32'(dout_valid[1]), 32'(tv[i].vld1));
            step();
        end

        // streaming: 16 words, consumer always ready
        for (int i = 0; i < 16; i++) src[1+i] = DW'(i);
        src_cnt = 17;
        dout_ready = 1'b1;
        count_pops(22);
        for (int g = 0; g < NL; g++) begin
            chk("stream_pops", g, 32'(pops[g]), 32'd16);
            chk("stream_gapless", g, 32'(last[g] - first[g]), 32'd15);
        end

        // backpressure: consumer stalls cycles 4..8
        for (int i = 0; i < 16; i++) src[17+i] = DW'(8'h10 + i);
        src_cnt = 33;
        for (int c = 0; c < 31; c++) begin
            dout_ready = !(c >= 4 && c <= 8);
            #1;
            if (!dout_ready) begin
                for (int g = 0; g < NL; g++) begin
                    chk("bp_valid", g, 32'(dout_valid[g]), 32'd1);
                    chk("bp_dout", g, 32'(dout[g]), 32'(src[exp_idx[g]]));
                end
            end
            if (c == 8) begin
                for (int g = 0; g < NL; g++) begin
                    chk("bp_level_full", g, 32'(level[g]), 32'(g + 2));
                    chk("bp_rd_en", g, 32'(mem_rd_en[g]), 32'd0);
                end
            end
            step();
        end
        for (int g = 0; g < NL; g++) chk("bp_total", g, 32'(exp_idx[g]), 32'd33);

        // drain: mem_empty rises while one read is in flight
        src[33] = 8'h40;
        src_cnt = 34;
        dout_ready = 1'b1;
        #1;
        for (int g = 0; g < NL; g++) chk("drain_rd_en", g, 32'(mem_rd_en[g]), 32'd1);
        step();
        #1;
        chk("drain_valid", 0, 32'(dout_valid[0]), 32'd1);
        chk("drain_dout", 0, 32'(dout[0]), 32'h40);
        chk("drain_valid", 1, 32'(dout_valid[1]), 32'd0);
        for (int g = 0; g < NL; g++) chk("drain_no_rd", g, 32'(mem_rd_en[g]), 32'd0);
        step();
        #1;
        chk("drain_done", 0, 32'(dout_valid[0]), 32'd0);
        chk("drain_valid", 1, 32'(dout_valid[1]), 32'd1);
        chk("drain_dout", 1, 32'(dout[1]), 32'h40);
        step();
        #1;
        for (int g = 0; g < NL; g++) begin
            chk("drain_done", g, 32'(dout_valid[g]), 32'd0);
            chk("drain_no_rd", g, 32'(mem_rd_en[g]), 32'd0);
            chk("drain_total", g, 32'(exp_idx[g]), 32'd34);
        end
        step();

        // reset mid-burst discards in-flight and buffered words
        for (int i = 0; i < 8; i++) src[34+i] = DW'(8'h50 + i);
        src_cnt = 42;
        run(3);
        rst = 1'b1;
        #1;
        chk_idle("rst_mid");
        run(2);
        #1;
        chk_idle("rst_hold");
        src_cnt = 0;
        for (int g = 0; g < NL; g++) exp_idx[g] = 0;
        for (int i = 0; i < 3; i++) src[i] = DW'(8'h70 + i);
        rst = 1'b0;
        run(1);
        src_cnt = 3;
        count_pops(8);
        for (int g = 0; g < NL; g++) begin
            chk("post_rst_pops", g, 32'(pops[g]), 32'd3);
            chk("post_rst_total", g, 32'(exp_idx[g]), 32'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
